// File: rtl/video_pkg.sv
// video_pkg: shared pattern-mode encodings, bar colour table and pipeline latency
package video_pkg;

    typedef enum logic [1:0] {
        MODE_GRADIENT = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_e;

    localparam int PG_LATENCY = 2;

    // {R,G,B} per bar, bar 0 in the low bits: white, yellow, cyan, green,
    // magenta, red, blue, black
    localparam logic [23:0] BAR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return BAR_TABLE[idx*3 +: 3];
    endfunction

endpackage

// File: rtl/video_pos_counter.sv
// video_pos_counter: sync edge detect plus pixel/line/frame position counters
//   clk, rst_n              : pixel clock, async active-low reset
//   hsync_i/vsync_i/data_en_i : timing inputs
//   x_o                     : pixel index of the current de cycle
//   y_o, frame_o            : low 8 bits of active-line and frame counters
//   vs_rise_o               : vsync rising edge this cycle
module video_pos_counter
    import video_pkg::*;
#(
    parameter int XY_W    = 12,
    parameter int FRAME_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hsync_i,
    input  logic            vsync_i,
    input  logic            data_en_i,
    output logic [XY_W-1:0] x_o,
    output logic [7:0]      y_o,
    output logic [7:0]      frame_o,
    output logic            vs_rise_o
);

    logic               hs_q, vs_q, line_act_q, line_act_d;
    logic               hs_rise, vs_rise;
    logic [XY_W-1:0]    x_q, x_d, y_q, y_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    always_comb begin
        hs_rise    = hsync_i & ~hs_q;
        vs_rise    = vsync_i & ~vs_q;
        x_d        = hs_rise ? '0 : x_q + XY_W'(data_en_i);
        line_act_d = ~hs_rise & (line_act_q | data_en_i);
        // only lines that carried active video advance y
        y_d        = vs_rise ? '0 : y_q + XY_W'(hs_rise & line_act_q);
        frame_d    = frame_q + FRAME_W'(vs_rise);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            line_act_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= '0;
        end else begin
            hs_q       <= hsync_i;
            vs_q       <= vsync_i;
            line_act_q <= line_act_d;
            x_q        <= x_d;
            y_q        <= y_d;
            frame_q    <= frame_d;
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q[7:0];
    assign frame_o   = frame_q[7:0];
    assign vs_rise_o = vs_rise;

endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: selectable test-pattern generator with 2-cycle delay-matched syncs
//   clk, rst_n            : pixel clock, async active-low reset
//   hsync/vsync/data_en   : timing inputs
//   mode, solid_rgb       : pattern select and SOLID colour, latched on vsync rise
//   out_hs/out_vs/out_de  : timing delayed by PG_LATENCY cycles
//   out_r/out_g/out_b     : pixel colour aligned with out_de
module pattern_gen
    import video_pkg::*;
#(
    parameter int COLOR_W    = 4,
    parameter int XY_W       = 12,
    parameter int FRAME_W    = 8,
    parameter int BAR_LOG2   = 4,
    parameter int CHECK_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 data_en,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic                 out_hs,
    output logic                 out_vs,
    output logic                 out_de,
    output logic [COLOR_W-1:0]   out_r,
    output logic [COLOR_W-1:0]   out_g,
    output logic [COLOR_W-1:0]   out_b
);

    logic [XY_W-1:0]       x_c, x1_q, bar_pos;
    logic [7:0]            y_c, f_c, y1_q, f1_q, xs, ys;
    logic                  vs_rise, chk;
    logic [2:0]            bar_idx, bar;
    mode_e                 mode_q;
    logic [3*COLOR_W-1:0]  solid_q, rgb_d, rgb_q;
    logic [PG_LATENCY-1:0] hs_dly_q, vs_dly_q, de_dly_q;

    video_pos_counter #(
        .XY_W    (XY_W),
        .FRAME_W (FRAME_W)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsync_i   (hsync),
        .vsync_i   (vsync),
        .data_en_i (data_en),
        .x_o       (x_c),
        .y_o       (y_c),
        .frame_o   (f_c),
        .vs_rise_o (vs_rise)
    );

    // colour stage works on stage-1 position; de_dly_q[0] is stage-1 de
    always_comb begin
        xs      = x1_q[7:0] + f1_q;
        ys      = y1_q + f1_q;
        bar_pos = x1_q >> BAR_LOG2;
        bar_idx = (bar_pos > XY_W'(7)) ? 3'd7 : bar_pos[2:0];
        bar     = bar_rgb(bar_idx);
        chk     = x1_q[CHECK_LOG2] ^ y1_q[CHECK_LOG2];
        rgb_d   = !de_dly_q[0]             ? '0 :
                  mode_q == MODE_GRADIENT  ? {COLOR_W'(ys >> (8-COLOR_W)),
                                              COLOR_W'(xs >> (8-COLOR_W)),
                                              COLOR_W'(xs)} :
                  mode_q == MODE_BARS      ? {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}},
                                              {COLOR_W{bar[0]}}} :
                  mode_q == MODE_CHECKER   ? {(3*COLOR_W){chk}} :
                                             solid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_GRADIENT;
            solid_q  <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            f1_q     <= '0;
            hs_dly_q <= '0;
            vs_dly_q <= '0;
            de_dly_q <= '0;
            rgb_q    <= '0;
        end else begin
            if (vs_rise) begin
                mode_q  <= mode_e'(mode);
                solid_q <= solid_rgb;
            end
            x1_q     <= x_c;
            y1_q     <= y_c;
            f1_q     <= f_c;
            hs_dly_q <= {hs_dly_q[PG_LATENCY-2:0], hsync};
            vs_dly_q <= {vs_dly_q[PG_LATENCY-2:0], vsync};
            de_dly_q <= {de_dly_q[PG_LATENCY-2:0], data_en};
            rgb_q    <= rgb_d;
        end
    end

    assign out_hs = hs_dly_q[PG_LATENCY-1];
    assign out_vs = vs_dly_q[PG_LATENCY-1];
    assign out_de = de_dly_q[PG_LATENCY-1];
    assign out_r  = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign out_g  = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign out_b  = rgb_q[COLOR_W-1:0];

endmodule
